// File: rtl/alt_dfe_avmm_pkg.sv
// Shared register map, control-word bit positions, response status bits and
// FSM state encoding for the DFE Avalon-MM master.
package alt_dfe_avmm_pkg;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_CH   = 2'd1;
  localparam logic [1:0] REG_WD   = 2'd2;
  localparam logic [1:0] REG_DATA = 2'd3;

  localparam int CTRL_BUSY   = 15;
  localparam int CTRL_INV_WD = 14;
  localparam int CTRL_INV_CH = 13;
  localparam int CTRL_RWN    = 1;
  localparam int CTRL_START  = 0;

  localparam int ST_INV_CH  = 0;
  localparam int ST_INV_WD  = 1;
  localparam int ST_TIMEOUT = 2;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_PRECHK  = 4'd1,
    S_WR_CH   = 4'd2,
    S_WR_WD   = 4'd3,
    S_WR_DATA = 4'd4,
    S_WR_CTRL = 4'd5,
    S_POLL    = 4'd6,
    S_RD_DATA = 4'd7,
    S_RESP    = 4'd8
  } state_t;

endpackage

// File: rtl/alt_dfe_avmm_master.sv
// Turns one channel/word read or write command into the Avalon-MM register
// sequence of the DFE slave: busy pre-check, address/data writes, start, poll.
module alt_dfe_avmm_master
  import alt_dfe_avmm_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int POLL_LIMIT = 1023
) (
  input  logic                  i_avmm_clk,
  input  logic                  i_resetn,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_rwn,
  input  logic [15:0]           i_cmd_chaddress,
  input  logic [15:0]           i_cmd_wdaddress,
  input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic [2:0]            o_rsp_status,
  output logic [ADDR_WIDTH-1:0] o_avmm_maddress,
  output logic                  o_avmm_mread,
  output logic                  o_avmm_mwrite,
  output logic [DATA_WIDTH-1:0] o_avmm_mwritedata,
  input  logic [DATA_WIDTH-1:0] i_avmm_mreaddata,
  input  logic                  i_avmm_mwaitrequest,
  output logic                  o_busy
);

  localparam int CNT_W = $clog2(POLL_LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST_POLL = CNT_W'(POLL_LIMIT - 1);

  state_t                state_q, state_d;
  logic                  rwn_q, rwn_d;
  logic [15:0]           ch_q, ch_d, wd_q, wd_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, rdata_q, rdata_d, wdata_q, wdata_d;
  logic [2:0]            status_q, status_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  mread_q, mread_d, mwrite_q, mwrite_d;
  logic [CNT_W-1:0]      poll_q, poll_d;

  logic                  req_rd;
  logic [1:0]            req_reg;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  bus_idle, xfer_done, busy_bit, at_limit;

  assign bus_idle  = ~mread_q & ~mwrite_q;
  assign xfer_done = (mread_q | mwrite_q) & ~i_avmm_mwaitrequest;
  assign busy_bit  = i_avmm_mreaddata[CTRL_BUSY];
  assign at_limit  = (poll_q == LAST_POLL);

  // Which register access each transfer state performs.
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    req_rd   = 1'b0;
    req_reg  = REG_CTRL;
    req_data = '0;
    case (state_q)
      S_PRECHK, S_POLL: req_rd = 1'b1;
      S_WR_CH: begin
        req_reg  = REG_CH;
        req_data = DATA_WIDTH'(ch_q);
      end
      S_WR_WD: begin
        req_reg  = REG_WD;
        req_data = DATA_WIDTH'(wd_q);
      end
      S_WR_DATA: begin
        req_reg  = REG_DATA;
        req_data = data_q;
      end
      S_WR_CTRL: begin
        req_data[CTRL_START] = 1'b1;
        req_data[CTRL_RWN]   = rwn_q;
      end
      S_RD_DATA: begin
        req_rd  = 1'b1;
        req_reg = REG_DATA;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rwn_d    = rwn_q;
    ch_d     = ch_q;
    wd_d     = wd_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    status_d = status_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mread_d  = mread_q;
    mwrite_d = mwrite_q;
    poll_d   = poll_q;

    // Issuing only from an idle bus leaves the strobe low for one cycle after every completion.
    if (state_q != S_IDLE && state_q != S_RESP) begin
      if (bus_idle) begin
        mread_d  = req_rd;
        mwrite_d = ~req_rd;
        addr_d   = ADDR_WIDTH'(req_reg);
        wdata_d  = req_data;
      end else if (xfer_done) begin
        mread_d  = 1'b0;
        mwrite_d = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          rwn_d    = i_cmd_rwn;
          ch_d     = i_cmd_chaddress;
          wd_d     = i_cmd_wdaddress;
          data_d   = i_cmd_wdata;
          rdata_d  = '0;
          status_d = '0;
          poll_d   = '0;
          state_d  = S_PRECHK;
        end
      end
      S_PRECHK, S_POLL: begin
        if (xfer_done) begin
          if (busy_bit) begin
            poll_d = poll_q + CNT_W'(1);
            if (at_limit) begin
              status_d[ST_TIMEOUT] = 1'b1;
              state_d              = S_RESP;
            end
          end else if (state_q == S_PRECHK) begin
            state_d = S_WR_CH;
          end else begin
            status_d[ST_INV_WD] = i_avmm_mreaddata[CTRL_INV_WD];
            status_d[ST_INV_CH] = i_avmm_mreaddata[CTRL_INV_CH];
            state_d = (rwn_q && !i_avmm_mreaddata[CTRL_INV_WD] && !i_avmm_mreaddata[CTRL_INV_CH])
                      ? S_RD_DATA : S_RESP;
          end
        end
      end
      S_WR_CH:   if (xfer_done) state_d = S_WR_WD;
      S_WR_WD:   if (xfer_done) state_d = rwn_q ? S_WR_CTRL : S_WR_DATA;
      S_WR_DATA: if (xfer_done) state_d = S_WR_CTRL;
      S_WR_CTRL: if (xfer_done) state_d = S_POLL;
      S_RD_DATA: begin
        if (xfer_done) begin
          rdata_d = i_avmm_mreaddata;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_avmm_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q  <= S_IDLE;
      rwn_q    <= 1'b0;
      ch_q     <= '0;
      wd_q     <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
      status_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mread_q  <= 1'b0;
      mwrite_q <= 1'b0;
      poll_q   <= '0;
    end else begin
      state_q  <= state_d;
      rwn_q    <= rwn_d;
      ch_q     <= ch_d;
      wd_q     <= wd_d;
      data_q   <= data_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mread_q  <= mread_d;
      mwrite_q <= mwrite_d;
      poll_q   <= poll_d;
    end
  end

  assign o_cmd_ready       = (state_q == S_IDLE);
  assign o_busy            = (state_q != S_IDLE);
  assign o_rsp_valid       = (state_q == S_RESP);
  assign o_rsp_rdata       = rdata_q;
  assign o_rsp_status      = status_q;
  assign o_avmm_maddress   = addr_q;
  assign o_avmm_mread      = mread_q;
  assign o_avmm_mwrite     = mwrite_q;
  assign o_avmm_mwritedata = wdata_q;

endmodule

// File: tb/tb_alt_dfe_avmm_master.sv
// Randomized bench: behavioural DFE slave on the Avalon side and a
// transaction-level model predicting the register sequence and response.
module tb_alt_dfe_avmm_master;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int LIMIT = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid, cmd_ready, cmd_rwn;
  logic [15:0]   cmd_ch, cmd_wd;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata_o;
  logic [2:0]    rsp_status_o;
  logic [AW-1:0] maddr;
  logic          mread, mwrite;
  logic [DW-1:0] mwdata, mrdata;
  logic          waitreq;
  logic          busy;

  always #5 clk = ~clk;

  alt_dfe_avmm_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .POLL_LIMIT(LIMIT)) dut (
    .i_avmm_clk(clk), .i_resetn(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_rwn(cmd_rwn),
    .i_cmd_chaddress(cmd_ch), .i_cmd_wdaddress(cmd_wd), .i_cmd_wdata(cmd_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata_o), .o_rsp_status(rsp_status_o),
    .o_avmm_maddress(maddr), .o_avmm_mread(mread), .o_avmm_mwrite(mwrite),
    .o_avmm_mwritedata(mwdata), .i_avmm_mreaddata(mrdata),
    .i_avmm_mwaitrequest(waitreq), .o_busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] init_val(input int c, input int w);
    if (c == 2 && w == 0) return 16'h1234;
    return 16'((c * 16 + w) * 'h0111) ^ 16'h5A00;
  endfunction

  // Slave configuration, written only by the stimulus process.
  int cfg_gen = 0, cfg_pre = 0, cfg_post = 0, cfg_wait = -1;

  // Slave state and observations, written only by the slave process.
  logic [32:0] log_q[$];
  logic [15:0] s_mem[0:7][0:2];
  logic [15:0] s_ch, s_wd, s_data;
  logic        s_rwn, started, init_done = 1'b0;
  int          pre_left, post_left, wait_left, seen_gen = 0;
  logic        in_xfer, gap_pending;
  logic [33:0] snap;
  int          stab_viol = 0, gap_viol = 0, both_viol = 0;

  always @(negedge clk) begin
    logic        b;
    logic [15:0] v;
    if (!init_done) begin
      for (int c = 0; c < 8; c++)
        for (int w = 0; w < 3; w++) s_mem[c][w] = init_val(c, w);
      init_done = 1'b1;
    end
    if (cfg_gen != seen_gen) begin
      seen_gen  = cfg_gen;
      pre_left  = cfg_pre;
      post_left = cfg_post;
      started   = 1'b0;
    end
    if (!rst_n) begin
      in_xfer = 1'b0; gap_pending = 1'b0; waitreq = 1'b0; mrdata = '0;
    end else begin
      if (gap_pending && (mread || mwrite)) gap_viol++;
      gap_pending = 1'b0;
      if (mread && mwrite) both_viol++;
      if (mread || mwrite) begin
        if (!in_xfer) begin
          in_xfer   = 1'b1;
          snap      = {mread, mwrite, maddr, mwdata};
          wait_left = (cfg_wait < 0) ? int'($urandom_range(0, 2)) : cfg_wait;
        end else if (snap != {mread, mwrite, maddr, mwdata}) begin
          stab_viol++;
        end
        if (wait_left > 0) begin
          waitreq = 1'b1; wait_left--; mrdata = 16'($urandom);
        end else begin
          waitreq = 1'b0; in_xfer = 1'b0; gap_pending = 1'b1;
          if (mwrite) begin
            log_q.push_back({1'b1, maddr, mwdata});
            case (maddr)
              16'd0: if (mwdata[0]) begin
                started = 1'b1;
                s_rwn   = mwdata[1];
                if (s_ch < 8 && s_wd < 3 && !mwdata[1]) s_mem[s_ch][s_wd] = s_data;
              end
              16'd1: s_ch = mwdata;
              16'd2: s_wd = mwdata;
              16'd3: s_data = mwdata;
              default: ;
            endcase
          end else begin
            log_q.push_back({1'b0, maddr, 16'h0});
            if (maddr == 16'd0) begin
              if (!started) begin b = (pre_left > 0); if (b) pre_left--; end
              else begin b = (post_left > 0); if (b) post_left--; end
              v = '0;
              v[15] = b;
              v[14] = started && (s_wd >= 3);
              v[13] = started && (s_ch >= 8);
              v[1]  = s_rwn;
              mrdata = v;
            end else if (maddr == 16'd3) begin
              mrdata = (started && s_rwn && s_ch < 8 && s_wd < 3) ? s_mem[s_ch][s_wd] : s_data;
            end else begin
              mrdata = 16'($urandom);
            end
          end
        end
      end else begin
        waitreq = 1'($urandom_range(0, 1));
        mrdata  = 16'($urandom);
      end
    end
  end

  // Response monitor.
  int          rsp_cnt = 0, rsp_long = 0, rsp_ready_bad = 0;
  logic [15:0] rsp_rdata;
  logic [2:0]  rsp_status;
  logic        prev_valid = 1'b0;

  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_cnt++;
      rsp_rdata  = rsp_rdata_o;
      rsp_status = rsp_status_o;
      if (prev_valid) rsp_long++;
      if (cmd_ready) rsp_ready_bad++;
    end
    prev_valid = rsp_valid;
  end

  // Transaction-level reference: expected register accesses and response.
  logic [15:0] m_mem[0:7][0:2];
  logic [32:0] exp_q[$];
  logic [2:0]  exp_status;
  logic [15:0] exp_rdata;

  task automatic build_expected(input logic rwn, input int ch, input int wd,
                                input logic [15:0] data, input int pre, input int post);
    int remaining;
    logic inv_ch, inv_wd;
    exp_q.delete();
    exp_status = 3'b000;
    exp_rdata  = 16'h0;
    if (pre >= LIMIT) begin
      repeat (LIMIT) exp_q.push_back({1'b0, 16'd0, 16'h0});
      exp_status = 3'b100;
      return;
    end
    repeat (pre + 1) exp_q.push_back({1'b0, 16'd0, 16'h0});
    exp_q.push_back({1'b1, 16'd1, 16'(ch)});
    exp_q.push_back({1'b1, 16'd2, 16'(wd)});
    if (!rwn) exp_q.push_back({1'b1, 16'd3, data});
    exp_q.push_back({1'b1, 16'd0, rwn ? 16'h0003 : 16'h0001});
    remaining = LIMIT - pre;
    if (post >= remaining) begin
      repeat (remaining) exp_q.push_back({1'b0, 16'd0, 16'h0});
      exp_status = 3'b100;
      return;
    end
    repeat (post + 1) exp_q.push_back({1'b0, 16'd0, 16'h0});
    inv_ch = (ch >= 8);
    inv_wd = (wd >= 3);
    exp_status = {1'b0, inv_wd, inv_ch};
    if (!inv_ch && !inv_wd) begin
      if (rwn) begin
        exp_q.push_back({1'b0, 16'd3, 16'h0});
        exp_rdata = m_mem[ch][wd];
      end else begin
        m_mem[ch][wd] = data;
      end
    end
  endtask

  task automatic run_cmd(input string tag, input logic rwn, input int ch, input int wd,
                         input logic [15:0] data, input int pre, input int post, input int wmode);
    int base, r0, n;
    logic done;
    build_expected(rwn, ch, wd, data, pre, post);
    cfg_pre = pre; cfg_post = post; cfg_wait = wmode; cfg_gen++;
    base = log_q.size();
    r0   = rsp_cnt;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rwn = rwn; cmd_ch = 16'(ch); cmd_wd = 16'(wd); cmd_wdata = data;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_rwn = 1'($urandom); cmd_ch = 16'($urandom); cmd_wd = 16'($urandom); cmd_wdata = 16'($urandom);
    check({tag, ".busy"}, busy, 1'b1);
    done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk);
      if (rsp_cnt != r0) done = 1'b1;
    end
    check({tag, ".rsp_seen"}, done, 1'b1);
    @(negedge clk);
    check({tag, ".ready_after"}, cmd_ready, 1'b1);
    check({tag, ".rsp_count"}, rsp_cnt - r0, 1);
    check({tag, ".status"}, rsp_status, exp_status);
    check({tag, ".rdata"}, rsp_rdata, exp_rdata);
    n = log_q.size() - base;
    check({tag, ".ntx"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      check($sformatf("%s.tx%0d", tag, i), log_q[base + i], exp_q[i]);
    check({tag, ".stable"}, stab_viol, 0);
    check({tag, ".gap"}, gap_viol, 0);
    check({tag, ".both_strobes"}, both_viol, 0);
    check({tag, ".rsp_one_cycle"}, rsp_long, 0);
    check({tag, ".ready_in_resp"}, rsp_ready_bad, 0);
  endtask

  initial begin
    int r0;
    logic found;
    cmd_valid = 1'b0; cmd_rwn = 1'b0; cmd_ch = '0; cmd_wd = '0; cmd_wdata = '0;
    for (int c = 0; c < 8; c++)
      for (int w = 0; w < 3; w++) m_mem[c][w] = init_val(c, w);
    #12;
    check("reset.ready", cmd_ready, 1'b1);
    check("reset.busy", busy, 1'b0);
    check("reset.rsp_valid", rsp_valid, 1'b0);
    check("reset.rdata", rsp_rdata_o, 16'h0);
    check("reset.status", rsp_status_o, 3'b000);
    check("reset.strobes", {mread, mwrite}, 2'b00);
    check("reset.addr", maddr, 16'h0);
    check("reset.wdata", mwdata, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_cmd("wr_basic", 1'b0, 5, 1, 16'hA5A5, 0, 3, -1);
    run_cmd("rd_basic", 1'b1, 2, 0, 16'h0, 1, 2, -1);
    run_cmd("rd_bad_wd", 1'b1, 2, 3, 16'h0, 0, 1, -1);
    run_cmd("rd_bad_ch", 1'b1, 9, 1, 16'h0, 0, 0, -1);
    run_cmd("poll_timeout", 1'b1, 1, 1, 16'h0, 0, 100000, -1);
    run_cmd("prechk_timeout", 1'b0, 1, 1, 16'h7777, 20, 0, -1);
    run_cmd("limit_edge", 1'b1, 4, 2, 16'h0, 3, 4, -1);
    run_cmd("wait4", 1'b1, 3, 2, 16'h0, 1, 1, 4);
    run_cmd("rd_back", 1'b1, 5, 1, 16'h0, 0, 0, 0);

    // Reset while the word-address write is on the bus.
    cfg_pre = 0; cfg_post = 2; cfg_wait = 1; cfg_gen++;
    r0 = rsp_cnt;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rwn = 1'b0; cmd_ch = 16'd4; cmd_wd = 16'd1; cmd_wdata = 16'hDEAD;
    @(negedge clk);
    cmd_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (mwrite && maddr == 16'd2) found = 1'b1;
    end
    check("rst.reach_wr_wd", found, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("rst.strobes", {mread, mwrite}, 2'b00);
    check("rst.addr", maddr, 16'h0);
    check("rst.busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst.no_rsp", rsp_cnt - r0, 0);
    check("rst.ready", cmd_ready, 1'b1);

    for (int k = 0; k < 14; k++) begin
      int pr, po;
      pr = int'($urandom_range(0, 9));
      po = int'($urandom_range(0, 9));
      run_cmd($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 9)), int'($urandom_range(0, 3)), 16'($urandom),
              (pr == 9) ? 10 : pr % 4, (po == 9) ? 12 : po % 5,
              ($urandom_range(0, 3) == 0) ? 0 : -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
